// File: rtl/seg7_prescale_seq_if.sv
// Pin-side bundle for the 7-segment prescaled sequencer.
// When SEG7_PWM_EN is defined the bundle also carries the bright[2:0] input.
interface seg7_prescale_seq_if #(
  parameter int unsigned SEL_W = 4
) ();
  logic             en;
  logic [SEL_W-1:0] div_sel;
  logic [1:0]       mode;
  logic             load;
  logic [3:0]       load_val;
  logic             invert;
`ifdef SEG7_PWM_EN
  logic [2:0]       bright;
`endif
  logic [6:0]       seg;
  logic             dp;
  logic             tick;

`ifdef SEG7_PWM_EN
  modport master (output en, div_sel, mode, load, load_val, invert, bright,
                  input  seg, dp, tick);
  modport slave  (input  en, div_sel, mode, load, load_val, invert, bright,
                  output seg, dp, tick);
`else
  modport master (output en, div_sel, mode, load, load_val, invert,
                  input  seg, dp, tick);
  modport slave  (input  en, div_sel, mode, load, load_val, invert,
                  output seg, dp, tick);
`endif
endinterface

// File: rtl/seg7_prescale_seq.sv
// Programmable prescaler driving a 4-bit up/down/bounce digit sequencer with
// registered hex 7-segment decode. Optional brightness PWM via SEG7_PWM_EN.
module seg7_prescale_seq #(
  parameter int unsigned DIV_W = 14,
  parameter int unsigned SEL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_prescale_seq_if.slave bus
);

  typedef enum logic [1:0] {MODE_HOLD, MODE_UP, MODE_DOWN, MODE_BOUNCE} mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       digit_q, digit_d;
  dir_e             dir_q, dir_d;
  logic             dp_q, dp_d;
  logic             tick_q, tick_d;
  logic [6:0]       seg_q, seg_d;

  logic [SEL_W-1:0] div_sel_c;
  logic [DIV_W-1:0] mask_c;
  logic             hit_c;
  logic             on_c;
  mode_e            mode_c;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  assign div_sel_c = bus.div_sel;
  assign mode_c    = mode_e'(bus.mode);

  // Low k+1 bits of the prescaler, k clamped to DIV_W-1 (selects above the width saturate).
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < DIV_W; i++) begin
      mask_c[i] = (32'(i) <= 32'(div_sel_c));
    end
  end

  assign hit_c = bus.en && ((cnt_q & mask_c) == mask_c);

  // Next-state: load wins over a tick in the same cycle; en=0 freezes everything but load.
  always_comb begin
    cnt_d   = cnt_q;
    digit_d = digit_q;
    dir_d   = dir_q;
    dp_d    = dp_q;
    tick_d  = 1'b0;
    seg_d   = seg_decode(digit_q);
    if (bus.load) begin
      digit_d = bus.load_val;
      cnt_d   = '0;
    end else if (bus.en) begin
      cnt_d = cnt_q + DIV_W'(1);
      if (hit_c) begin
        tick_d = 1'b1;
        case (mode_c)
          MODE_UP: begin
            digit_d = digit_q + 4'd1;
            if (digit_q == 4'hF) dp_d = ~dp_q;
          end
          MODE_DOWN: begin
            digit_d = digit_q - 4'd1;
            if (digit_q == 4'h0) dp_d = ~dp_q;
          end
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (digit_q == 4'hF) begin
                dir_d   = DIR_DOWN;
                digit_d = 4'hE;
              end else begin
                digit_d = digit_q + 4'd1;
              end
            end else begin
              if (digit_q == 4'h0) begin
                dir_d   = DIR_UP;
                digit_d = 4'h1;
                dp_d    = ~dp_q;
              end else begin
                digit_d = digit_q - 4'd1;
              end
            end
          end
          default: digit_d = digit_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      digit_q <= 4'h0;
      dir_q   <= DIR_UP;
      dp_q    <= 1'b0;
      tick_q  <= 1'b0;
      seg_q   <= 7'h3F;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      dir_q   <= dir_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
      seg_q   <= seg_d;
    end
  end

`ifdef SEG7_PWM_EN
  logic [2:0] pwm_cnt_q, pwm_cnt_d;

  // Free-running duty counter; independent of en so dimming never stalls.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= 3'd0;
    else        pwm_cnt_q <= pwm_cnt_d;
  end

  assign on_c = (pwm_cnt_q <= bus.bright);
`else
  assign on_c = 1'b1;
`endif

  // Polarity is applied after the register so invert has no latency.
  assign bus.seg  = (on_c ? seg_q : 7'h00) ^ {7{bus.invert}};
  assign bus.dp   = (on_c & dp_q) ^ bus.invert;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_seg7_prescale_seq.sv
// Directed bench for seg7_prescale_seq: decode table plus tick/load/bounce/freeze sequences.
module tb_seg7_prescale_seq;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  seg7_prescale_seq_if #(.SEL_W(4)) bus ();

  seg7_prescale_seq #(.DIV_W(14), .SEL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] val;
    logic       inv;
    logic [6:0] seg;
  } vec_t;

  vec_t vec [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Counts negedges from 'start' until tick is seen high; a timeout counts as a failure.
  task automatic wait_tick(input int start, input int budget, output int n);
    n = start;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick && n < budget);
    if (!bus.tick) check("tick_timeout", 32'd0, 32'd1);
  endtask

  int n;
  int d;
  logic exp_dp;

  initial begin
    n_run  = 0;
    n_fail = 0;
    vec[0]  = '{4'h0, 1'b0, 7'h3F};
    vec[1]  = '{4'h1, 1'b1, 7'h06};
    vec[2]  = '{4'h2, 1'b0, 7'h5B};
    vec[3]  = '{4'h3, 1'b1, 7'h4F};
    vec[4]  = '{4'h4, 1'b0, 7'h66};
    vec[5]  = '{4'h5, 1'b0, 7'h6D};
    vec[6]  = '{4'h6, 1'b1, 7'h7D};
    vec[7]  = '{4'h7, 1'b0, 7'h07};
    vec[8]  = '{4'h8, 1'b0, 7'h7F};
    vec[9]  = '{4'h9, 1'b1, 7'h6F};
    vec[10] = '{4'hA, 1'b0, 7'h77};
    vec[11] = '{4'hB, 1'b0, 7'h7C};
    vec[12] = '{4'hC, 1'b1, 7'h39};
    vec[13] = '{4'hD, 1'b0, 7'h5E};
    vec[14] = '{4'hE, 1'b0, 7'h79};
    vec[15] = '{4'hF, 1'b1, 7'h71};

    bus.en       = 1'b0;
    bus.div_sel  = 4'd0;
    bus.mode     = 2'b00;
    bus.load     = 1'b0;
    bus.load_val = 4'h0;
    bus.invert   = 1'b0;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_seg", 32'(bus.seg), 32'h3F);
    check("reset_dp", 32'(bus.dp), 32'h0);
    check("reset_tick", 32'(bus.tick), 32'h0);
    bus.invert = 1'b1;
    #1;
    check("reset_seg_inv", 32'(bus.seg), 32'h40);
    bus.invert = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Decode table via load with en=0 (load still acts); seg valid two cycles later.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.load     = 1'b1;
      bus.load_val = vec[i].val;
      bus.invert   = vec[i].inv;
      @(negedge clk);
      bus.load = 1'b0;
      @(negedge clk);
      check($sformatf("decode_%0h", i), 32'(bus.seg), 32'(vec[i].seg ^ {7{vec[i].inv}}));
    end
    bus.invert = 1'b0;

    // Count up, period 8: 16 ticks bring the digit back to 0 and toggle dp.
    @(negedge clk);
    bus.load     = 1'b1;
    bus.load_val = 4'h0;
    @(negedge clk);
    bus.load    = 1'b0;
    bus.div_sel = 4'd2;
    bus.mode    = 2'b01;
    bus.en      = 1'b1;
    for (int t = 0; t < 16; t++) begin
      wait_tick((t == 0) ? 0 : 1, 40, n);
      check($sformatf("up_period_%0d", t), 32'(n), 32'd8);
      @(negedge clk);
      check($sformatf("up_tick_width_%0d", t), 32'(bus.tick), 32'd0);
      check($sformatf("up_seg_%0d", t), 32'(bus.seg), 32'(vec[(t + 1) % 16].seg));
    end
    check("up_wrap_dp", 32'(bus.dp), 32'd1);

    // Down with div_sel clamped to 13: period 16384, 0 -> F toggles dp back to 0.
    bus.load     = 1'b1;
    bus.load_val = 4'h0;
    bus.mode     = 2'b10;
    bus.div_sel  = 4'd15;
    @(negedge clk);
    bus.load = 1'b0;
    wait_tick(1, 17000, n);
    check("down_clamp_period", 32'(n), 32'd16385);
    @(negedge clk);
    check("down_seg_F", 32'(bus.seg), 32'h71);
    check("down_wrap_dp", 32'(bus.dp), 32'd0);

    // Load on the exact prescaler hit: tick suppressed, digit 9, full period restarts.
    bus.div_sel = 4'd2;
    bus.mode    = 2'b01;
    wait_tick(0, 40, n);
    repeat (7) @(negedge clk);
    bus.load     = 1'b1;
    bus.load_val = 4'h9;
    @(negedge clk);
    bus.load = 1'b0;
    check("load_blocks_tick", 32'(bus.tick), 32'd0);
    @(negedge clk);
    check("load_seg_9", 32'(bus.seg), 32'h6F);
    wait_tick(2, 40, n);
    check("load_restart_period", 32'(n), 32'd9);
    @(negedge clk);
    check("load_then_step_A", 32'(bus.seg), 32'h77);

    // Bounce from 14 with dir up: 15,14,...,0,1,2; dp toggles only at 0 -> 1.
    // dp is 1 here: the sync tick above wrapped F -> 0.
    exp_dp       = 1'b1;
    bus.en       = 1'b0;
    bus.mode     = 2'b11;
    bus.div_sel  = 4'd0;
    bus.load     = 1'b1;
    bus.load_val = 4'hE;
    @(negedge clk);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    for (int t = 0; t < 18; t++) begin
      d = (t < 16) ? (15 - t) : (t - 15);
      if (t == 16) exp_dp = ~exp_dp;
      wait_tick((t == 0) ? 0 : 1, 20, n);
      @(negedge clk);
      check($sformatf("bounce_seg_%0d", t), 32'(bus.seg), 32'(vec[d].seg));
      check($sformatf("bounce_dp_%0d", t), 32'(bus.dp), 32'(exp_dp));
    end

    // en=0 freezes digit and forces tick low; resuming steps 2 -> 3.
    bus.en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("freeze_tick_%0d", c), 32'(bus.tick), 32'd0);
      check($sformatf("freeze_seg_%0d", c), 32'(bus.seg), 32'h5B);
    end
    bus.en = 1'b1;
    wait_tick(0, 20, n);
    @(negedge clk);
    check("resume_seg_3", 32'(bus.seg), 32'h4F);

    // Asynchronous reset mid-operation.
    #2 rst_n = 1'b0;
    #1;
    check("midrst_seg", 32'(bus.seg), 32'h3F);
    check("midrst_dp", 32'(bus.dp), 32'd0);
    check("midrst_tick", 32'(bus.tick), 32'd0);
    @(negedge clk);
    check("midrst_hold_seg", 32'(bus.seg), 32'h3F);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
